// File: rtl/split_sweep_sched.sv
// split_sweep_sched
//   Sweeps a rectangular (var_1, var_2) candidate range one pair per cycle,
//   tests each pair against the split constraint set (c1 & c2 & c5), and
//   streams satisfying pairs out through a one-entry valid/ready register.
//   Hit and candidate counts are reported for the most recent sweep.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle sweep request, honoured only in IDLE
//   abort             terminate the sweep, drop any pending pair, no done pulse
//   v1_lo/v1_hi       inclusive var_1 range (13 bits), latched on start
//   v2_lo/v2_hi       inclusive var_2 range (14 bits), latched on start
//   early_exit        (only with SPLIT_SWEEP_EARLY_EXIT_EN) stop after first hit
//   busy, done        status: not IDLE / one-cycle completion pulse
//   out_valid/ready   result handshake, out_v1/out_v2 carry the pair
//   hit_count         satisfying pairs this sweep, saturating
//   cand_count        candidates evaluated this sweep, wrapping
//
// Optional feature macro: SPLIT_SWEEP_EARLY_EXIT_EN
module split_sweep_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [12:0] v1_lo,
  input  logic [12:0] v1_hi,
  input  logic [13:0] v2_lo,
  input  logic [13:0] v2_hi,
`ifdef SPLIT_SWEEP_EARLY_EXIT_EN
  input  logic        early_exit,
`endif
  output logic        busy,
  output logic        done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_v1,
  output logic [13:0] out_v2,
  output logic [15:0] hit_count,
  output logic [31:0] cand_count
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DRAIN, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        ov_q, ov_d;
  logic [12:0] ov1_q, ov1_d;
  logic [13:0] ov2_q, ov2_d;
  logic [15:0] hit_q, hit_d;
  logic [31:0] cand_q, cand_d;
  logic [12:0] v1_lo_q, v1_lo_d, v1_hi_q, v1_hi_d, cur1_q, cur1_d;
  logic [13:0] v2_lo_q, v2_lo_d, v2_hi_q, v2_hi_d, cur2_q, cur2_d;
  logic        ee_q, ee_d;

  logic        hit;
  logic        stall;

  function automatic logic [15:0] sat_inc16(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  function automatic logic constraint_ok(input logic [12:0] a, input logic [13:0] b);
    logic [15:0] c1_sum;
    logic        c1, c2, c5;
    c1_sum = {2'b00, b} - 16'h39DD + 16'hE8C3;
    c1     = (c1_sum != 16'h0000);
    c2     = (a != 13'd0);
    c5     = ({1'b0, a} != (b >> 1));
    return c1 & c2 & c5;
  endfunction

  assign hit   = constraint_ok(cur1_q, cur2_q);
  // A full register that is not drained this cycle blocks all progress.
  assign stall = ov_q & ~out_ready;

  always_comb begin
    state_d = state_q;
    ov_d    = ov_q & ~out_ready;
    ov1_d   = ov1_q;
    ov2_d   = ov2_q;
    hit_d   = hit_q;
    cand_d  = cand_q;
    v1_lo_d = v1_lo_q;
    v1_hi_d = v1_hi_q;
    v2_lo_d = v2_lo_q;
    v2_hi_d = v2_hi_q;
    cur1_d  = cur1_q;
    cur2_d  = cur2_q;
    ee_d    = ee_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          v1_lo_d = v1_lo;
          v1_hi_d = v1_hi;
          v2_lo_d = v2_lo;
          v2_hi_d = v2_hi;
          cur1_d  = v1_lo;
          cur2_d  = v2_lo;
          hit_d   = 16'd0;
          cand_d  = 32'd0;
`ifdef SPLIT_SWEEP_EARLY_EXIT_EN
          ee_d    = early_exit;
`else
          ee_d    = 1'b0;
`endif
          if ((v1_lo > v1_hi) || (v2_lo > v2_hi)) state_d = S_DONE;
          else                                    state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!stall) begin
          cand_d = cand_q + 32'd1;
          if (hit) begin
            ov_d  = 1'b1;
            ov1_d = cur1_q;
            ov2_d = cur2_q;
            hit_d = sat_inc16(hit_q);
          end
          // Compare against hi before stepping so a field-max endpoint never wraps.
          if ((cur1_q == v1_hi_q) && (cur2_q == v2_hi_q)) begin
            state_d = S_DRAIN;
          end else if (cur2_q == v2_hi_q) begin
            cur2_d = v2_lo_q;
            cur1_d = cur1_q + 13'd1;
          end else begin
            cur2_d = cur2_q + 14'd1;
          end
          if (ee_q && hit) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!ov_q) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: drop the pending pair, freeze the counts.
    if (abort) begin
      state_d = S_IDLE;
      ov_d    = 1'b0;
      hit_d   = hit_q;
      cand_d  = cand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ov_q    <= 1'b0;
      ov1_q   <= 13'd0;
      ov2_q   <= 14'd0;
      hit_q   <= 16'd0;
      cand_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      ov1_q   <= ov1_d;
      ov2_q   <= ov2_d;
      hit_q   <= hit_d;
      cand_q  <= cand_d;
    end
  end

  // Range, cursor and option latch are only meaningful after a start.
  always_ff @(posedge clk) begin
    v1_lo_q <= v1_lo_d;
    v1_hi_q <= v1_hi_d;
    v2_lo_q <= v2_lo_d;
    v2_hi_q <= v2_hi_d;
    cur1_q  <= cur1_d;
    cur2_q  <= cur2_d;
    ee_q    <= ee_d;
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign out_valid  = ov_q;
  assign out_v1     = ov1_q;
  assign out_v2     = ov2_q;
  assign hit_count  = hit_q;
  assign cand_count = cand_q;

endmodule

// File: tb/tb_split_sweep_sched.sv
module tb_split_sweep_sched;

  logic        clk = 1'b0;
  logic        rst, start, abort, out_ready;
  logic [12:0] v1_lo, v1_hi;
  logic [13:0] v2_lo, v2_hi;
  logic        busy, done, out_valid;
  logic [12:0] out_v1;
  logic [13:0] out_v2;
  logic [15:0] hit_count;
  logic [31:0] cand_count;
`ifdef SPLIT_SWEEP_EARLY_EXIT_EN
  logic        early_exit = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  split_sweep_sched dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .v1_lo      (v1_lo),
    .v1_hi      (v1_hi),
    .v2_lo      (v2_lo),
    .v2_hi      (v2_hi),
`ifdef SPLIT_SWEEP_EARLY_EXIT_EN
    .early_exit (early_exit),
`endif
    .busy       (busy),
    .done       (done),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_v1     (out_v1),
    .out_v2     (out_v2),
    .hit_count  (hit_count),
    .cand_count (cand_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive ranges and pulse start; on return the bench sits in cycle 1.
  task automatic go(input logic [12:0] a_lo, input logic [12:0] a_hi,
                    input logic [13:0] b_lo, input logic [13:0] b_hi);
    v1_lo = a_lo; v1_hi = a_hi; v2_lo = b_lo; v2_hi = b_hi;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    v1_lo = '0; v1_hi = '0; v2_lo = '0; v2_hi = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_v1", out_v1, 0);
    chk("rst_v2", out_v2, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_cand", cand_count, 0);
    rst = 1'b0;
    tick();

    // v1=[0,0]: var_1 zero never satisfies c2
    go(13'd0, 13'd0, 14'd0, 14'd3);
    chk("t1_busy_c1", busy, 1);
    for (int c = 1; c <= 5; c++) begin
      chk("t1_no_ovalid", out_valid, 0);
      chk("t1_no_done", done, 0);
      tick();
    end
    chk("t1_done_c6", done, 1);
    chk("t1_hit", hit_count, 0);
    chk("t1_cand", cand_count, 4);
    tick();
    chk("t1_idle", busy, 0);
    chk("t1_done_pulse", done, 0);

    // v1=[1,1]: hits at (1,0),(1,1); (1,2),(1,3) fail c5
    go(13'd1, 13'd1, 14'd0, 14'd3);
    chk("t2_c1_ov", out_valid, 0);
    tick();
    chk("t2_c2_ov", out_valid, 1);
    chk("t2_c2_v1", out_v1, 1);
    chk("t2_c2_v2", out_v2, 0);
    tick();
    chk("t2_c3_ov", out_valid, 1);
    chk("t2_c3_v2", out_v2, 1);
    tick();
    chk("t2_c4_ov", out_valid, 0);
    tick();
    chk("t2_c5_done", done, 0);
    tick();
    chk("t2_c6_done", done, 1);
    chk("t2_hit", hit_count, 2);
    chk("t2_cand", cand_count, 4);
    tick();

    // Same range with back-pressure in cycles 1..10
    out_ready = 1'b0;
    go(13'd1, 13'd1, 14'd0, 14'd3);
    tick();
    chk("t3_c2_ov", out_valid, 1);
    chk("t3_c2_v2", out_v2, 0);
    chk("t3_c2_cand", cand_count, 1);
    for (int c = 3; c <= 10; c++) tick();
    chk("t3_c10_ov", out_valid, 1);
    chk("t3_c10_v1", out_v1, 1);
    chk("t3_c10_v2", out_v2, 0);
    chk("t3_c10_cand", cand_count, 1);
    chk("t3_c10_hit", hit_count, 1);
    out_ready = 1'b1;
    tick();
    chk("t3_c11_ov", out_valid, 1);
    chk("t3_c11_v2", out_v2, 1);
    chk("t3_c11_cand", cand_count, 2);
    tick();
    chk("t3_c12_ov", out_valid, 0);
    tick(); tick();
    chk("t3_c14_done", done, 1);
    chk("t3_hit", hit_count, 2);
    chk("t3_cand", cand_count, 4);
    tick();

    // Abort in cycle 3 of v1=[2,3], v2=[4,7]
    go(13'd2, 13'd3, 14'd4, 14'd7);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_c4_busy", busy, 0);
    chk("t4_c4_ov", out_valid, 0);
    chk("t4_c4_cand", cand_count, 2);
    for (int c = 0; c < 3; c++) begin
      chk("t4_no_done", done, 0);
      tick();
    end
    go(13'd2, 13'd3, 14'd4, 14'd7);
    chk("t4r_c1_cand", cand_count, 0);
    chk("t4r_c1_hit", hit_count, 0);
    tick(); tick(); tick();
    chk("t4r_c4_ov", out_valid, 1);
    chk("t4r_c4_v1", out_v1, 2);
    chk("t4r_c4_v2", out_v2, 6);
    tick(); tick();
    chk("t4r_c6_v1", out_v1, 3);
    chk("t4r_c6_v2", out_v2, 4);
    tick(); tick(); tick();
    chk("t4r_c9_done", done, 0);
    tick();
    chk("t4r_c10_done", done, 1);
    chk("t4r_hit", hit_count, 4);
    chk("t4r_cand", cand_count, 8);
    tick();

    // Empty var_1 range
    go(13'd5, 13'd4, 14'd0, 14'd3);
    chk("t5_c1_done", done, 1);
    chk("t5_hit", hit_count, 0);
    chk("t5_cand", cand_count, 0);
    tick();
    chk("t5_c2_busy", busy, 0);

    // start while busy is ignored
    go(13'd1, 13'd1, 14'd0, 14'd3);
    tick();
    v1_lo = 13'd0; v1_hi = 13'd0; v2_lo = 14'd9; v2_hi = 14'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t5b_c5_busy", busy, 1);
    tick();
    chk("t5b_c6_done", done, 1);
    chk("t5b_hit", hit_count, 2);
    chk("t5b_cand", cand_count, 4);
    tick();
    chk("t5b_c7_busy", busy, 0);

    // Field-max endpoints: (1FFF,3FFE),(1FFF,3FFF) both fail c5
    go(13'h1FFF, 13'h1FFF, 14'h3FFE, 14'h3FFF);
    tick(); tick();
    chk("t6_c3_drain", busy, 1);
    chk("t6_c3_done", done, 0);
    tick();
    chk("t6_c4_done", done, 1);
    chk("t6_cand", cand_count, 2);
    chk("t6_hit", hit_count, 0);
    chk("t6_ov", out_valid, 0);
    tick();
    chk("t6_c5_busy", busy, 0);

`ifdef SPLIT_SWEEP_EARLY_EXIT_EN
    early_exit = 1'b1;
    go(13'd1, 13'd1, 14'd0, 14'd3);
    early_exit = 1'b0;
    tick();
    chk("t7_c2_ov", out_valid, 1);
    chk("t7_c2_v2", out_v2, 0);
    tick();
    chk("t7_c3_ov", out_valid, 0);
    tick();
    chk("t7_c4_done", done, 1);
    chk("t7_hit", hit_count, 1);
    chk("t7_cand", cand_count, 1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
